// File: rtl/adc_sample_sched.sv
// adc_sample_sched: paces AD7980 conversions at a fixed rate and buffers each result on a valid/ready stream.
// Latency: adc_start one cycle after the rate tick; out_valid rises one edge after busy is seen low.
// Backpressure: single-entry output register; an unread word is overwritten and sticky overrun is set.
// Optional feature: define ADC_SCHED_AVG_EN to emit the mean of 2**AVG_LOG2 samples per output word.
module adc_sample_sched #(
  parameter int CLK_PER_SAMPLE = 200,
  parameter int BITS           = 16,
  parameter int TIMEOUT        = 1024,
  parameter int AVG_LOG2       = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  output logic            adc_start,
  input  logic            adc_busy,
  input  logic [BITS-1:0] adc_data,
  output logic [BITS-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready,
  input  logic            clr_flags,
  output logic            overrun,
  output logic            missed_tick,
  output logic            timeout_err
);

  localparam int TW = $clog2(CLK_PER_SAMPLE);
  localparam int OW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  // Reject configurations the timer and averager cannot honour.
  if (CLK_PER_SAMPLE < 8 || AVG_LOG2 < 0) begin : g_bad_param
    $error("adc_sample_sched: CLK_PER_SAMPLE must be >= 8 and AVG_LOG2 >= 0");
  end

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_BUSY = 3'd2,
    CONV      = 3'd3,
    CAPTURE   = 3'd4
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [TW-1:0]   tmr;
  logic            tick;
  logic            pending;
  logic            consume;
  logic [OW-1:0]   tmo_cnt;
  logic            cap;
  logic            load;
  logic [BITS-1:0] load_dat;
  logic            ovr_set;

  assign tick = enable && (tmr == TW'(CLK_PER_SAMPLE - 1));

  // Free-running rate timer while enabled; tick on the wrap back to zero.
  always_ff @(posedge clk) begin
    if (rst || !enable || tick) tmr <= '0;
    else                        tmr <= tmr + 1'b1;
  end

  // Single-deep tick request; dropped when the timer is disabled.
  always_ff @(posedge clk) begin
    if (rst) pending <= 1'b0;
    else     pending <= tick | (pending & ~consume & enable);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and per-state strobes; busy wins over a timeout in the same cycle.
  always_comb begin
    state_nxt   = state;
    consume     = 1'b0;
    adc_start   = 1'b0;
    timeout_err = 1'b0;
    cap         = 1'b0;
    case (state)
      IDLE: begin
        if (pending) begin
          consume   = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        adc_start = 1'b1;
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (adc_busy) begin
          state_nxt = CONV;
        end else if (tmo_cnt == OW'(TIMEOUT - 1)) begin
          timeout_err = 1'b1;
          state_nxt   = IDLE;
        end
      end
      CONV: begin
        if (!adc_busy) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        cap       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Clocks spent waiting for busy; zeroed by every start pulse.
  always_ff @(posedge clk) begin
    if (rst || state == START)  tmo_cnt <= '0;
    else if (state == WAIT_BUSY) tmo_cnt <= tmo_cnt + 1'b1;
  end

`ifdef ADC_SCHED_AVG_EN
  localparam int AW = BITS + AVG_LOG2;
  localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  logic [AW-1:0] acc;
  logic [AW-1:0] acc_sum;
  logic [CW-1:0] acc_cnt;
  logic          acc_last;

  assign acc_sum  = acc + AW'(adc_data);
  assign acc_last = (acc_cnt == CW'((1 << AVG_LOG2) - 1));
  assign load     = cap && acc_last;
  assign load_dat = BITS'(acc_sum >> AVG_LOG2);

  // Sum samples until the block is complete; a disabled, idle scheduler restarts the block.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      acc_cnt <= '0;
    end else if (cap) begin
      if (acc_last) begin
        acc     <= '0;
        acc_cnt <= '0;
      end else begin
        acc     <= acc_sum;
        acc_cnt <= acc_cnt + 1'b1;
      end
    end else if (!enable && state == IDLE) begin
      acc     <= '0;
      acc_cnt <= '0;
    end
  end
`else
  assign load     = cap;
  assign load_dat = adc_data;
`endif

  // Output holding register; a load with ready high also retires the old word.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      out_data  <= load_dat;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign ovr_set = load && out_valid && !out_ready;

  // Sticky flags; a set event beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun     <= 1'b0;
      missed_tick <= 1'b0;
    end else begin
      overrun     <= ovr_set | (overrun & ~clr_flags);
      missed_tick <= (tick & pending) | (missed_tick & ~clr_flags);
    end
  end

endmodule

// File: tb/tb_adc_sample_sched.sv
// Bench for adc_sample_sched: behavioural ADC core plus a timestamp-based reference of the scheduler.
// Each conversion pass is modelled by the edges at which it starts, sees busy and loads its result.
`timescale 1ns/1ps
module tb_adc_sample_sched;
  localparam int CPS  = 200;
  localparam int BITS = 16;
  localparam int TMO  = 1024;
`ifdef ADC_SCHED_AVG_EN
  localparam int AVG  = 2;
`endif

  logic            clk;
  logic            rst;
  logic            enable;
  logic            adc_start;
  logic            adc_busy;
  logic [BITS-1:0] adc_data;
  logic [BITS-1:0] out_data;
  logic            out_valid;
  logic            out_ready;
  logic            clr_flags;
  logic            overrun;
  logic            missed_tick;
  logic            timeout_err;

  adc_sample_sched #(
    .CLK_PER_SAMPLE(CPS),
    .BITS(BITS),
    .TIMEOUT(TMO),
    .AVG_LOG2(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .adc_start(adc_start),
    .adc_busy(adc_busy),
    .adc_data(adc_data),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .clr_flags(clr_flags),
    .overrun(overrun),
    .missed_tick(missed_tick),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s at edge %0d: got 0x%0h, want 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  // Reference state: timer/flags as integers, passes as edge timestamps.
  int              m_tcnt;
  bit              m_pend, m_missed, m_ovr, m_valid;
  logic [BITS-1:0] m_data;
  int              idle_from, start_edge, to_cycle, load_edge, busy_on, busy_off;
  logic [BITS-1:0] pass_word;
  int              acc, acnt;

  // Stimulus knobs.
  int  lat_lo = 1, lat_hi = 1, len_lo = 60, len_hi = 60;
  int  ready_pct = 100, clr_pct = 0, en_flip = 0;
  bit  no_busy = 0;
  logic [BITS-1:0] word_q[$];

  task automatic model_edge();
    bit tick, idle_old, consume, load, set_ov;
    int lat, blen;
    logic [BITS-1:0] word;
    if (rst) begin
      m_tcnt = 0; m_pend = 0; m_missed = 0; m_ovr = 0; m_valid = 0; m_data = '0;
      idle_from = cyc; start_edge = -1; to_cycle = -1; load_edge = -1;
      busy_on = -1; busy_off = -1; acc = 0; acnt = 0;
      return;
    end
    tick     = enable && (m_tcnt == CPS - 1);
    m_tcnt   = (!enable || tick) ? 0 : m_tcnt + 1;
    idle_old = (cyc - 1 >= idle_from);
    consume  = idle_old && m_pend;
    m_missed = (tick && m_pend) || (m_missed && !clr_flags);
    m_pend   = tick || (m_pend && !consume && enable);
    if (consume) begin
      start_edge = cyc;
      if (no_busy) begin
        to_cycle  = cyc + TMO;
        idle_from = cyc + TMO + 1;
        busy_on = -1; busy_off = -1; load_edge = -1;
      end else begin
        lat       = int'($urandom_range(lat_hi, lat_lo));
        blen      = int'($urandom_range(len_hi, len_lo));
        busy_on   = cyc + lat + 1;
        busy_off  = cyc + lat + blen + 1;
        load_edge = cyc + lat + blen + 2;
        idle_from = load_edge;
        if (word_q.size() > 0) pass_word = word_q.pop_front();
        else                   pass_word = BITS'($urandom);
      end
    end
    load = (cyc == load_edge);
    word = pass_word;
`ifdef ADC_SCHED_AVG_EN
    if (!enable && idle_old) begin acc = 0; acnt = 0; end
    if (load) begin
      acc  = acc + int'(pass_word);
      acnt = acnt + 1;
      if (acnt == (1 << AVG)) begin
        word = BITS'(acc >> AVG);
        acc = 0; acnt = 0;
      end else begin
        load = 0;
      end
    end
`endif
    set_ov = 0;
    if (load) begin
      set_ov  = m_valid && !out_ready;
      m_data  = word;
      m_valid = 1;
    end else if (m_valid && out_ready) begin
      m_valid = 0;
    end
    m_ovr = set_ov || (m_ovr && !clr_flags);
  endtask

  task automatic check_outputs();
    check_eq("adc_start",   adc_start,   cyc == start_edge);
    check_eq("timeout_err", timeout_err, cyc == to_cycle);
    check_eq("out_valid",   out_valid,   m_valid);
    check_eq("out_data",    out_data,    m_data);
    check_eq("overrun",     overrun,     m_ovr);
    check_eq("missed_tick", missed_tick, m_missed);
  endtask

  // ADC core: busy for the scheduled window, new data on the edge busy falls.
  task automatic adc_drive();
    adc_busy = (busy_on >= 0) && (cyc + 1 >= busy_on) && (cyc + 1 < busy_off);
    if (busy_off >= 0 && cyc + 1 == busy_off) adc_data = pass_word;
  endtask

  task automatic stim_drive();
    out_ready = ($urandom_range(99, 0) < ready_pct);
    clr_flags = ($urandom_range(99, 0) < clr_pct);
    if ($urandom_range(999, 0) < en_flip) enable = ~enable;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      cyc++;
      model_edge();
      @(negedge clk);
      check_outputs();
      adc_drive();
      stim_drive();
    end
  endtask

  task automatic wait_busy(input string tag);
    int k;
    k = 0;
    while (!adc_busy && k < 2000) begin
      run(1);
      k++;
    end
    check_eq(tag, adc_busy, 1'b1);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; out_ready = 1'b0; clr_flags = 1'b0;
    adc_busy = 1'b0; adc_data = '0;
    idle_from = 0; start_edge = -1; to_cycle = -1; load_edge = -1; busy_on = -1; busy_off = -1;
    m_tcnt = 0; m_pend = 0; m_missed = 0; m_ovr = 0; m_valid = 0; m_data = '0;
    acc = 0; acnt = 0; pass_word = '0;
    run(3);
    rst = 1'b0;

    // Steady rate with known words, including the latency probe word.
    word_q = {16'h1234, 16'hABCD, 16'h8001};
`ifdef ADC_SCHED_AVG_EN
    word_q = {16'd10, 16'd20, 16'd30, 16'd41, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
`endif
    enable = 1'b1; out_ready = 1'b1; ready_pct = 100;
    run(1900);

    // Downstream stalled across three loads, then flags cleared.
    ready_pct = 0; out_ready = 1'b0;
    run(650);
    clr_flags = 1'b1;
    run(1);
    ready_pct = 100; out_ready = 1'b1;
    run(300);

    // Conversions longer than the tick period.
    len_lo = 230; len_hi = 260;
    run(1200);
    clr_flags = 1'b1;
    run(1);

    // ADC never answers: timeout, then normal service resumes.
    len_lo = 40; len_hi = 90;
    no_busy = 1;
    run(2600);
    no_busy = 0;
    run(600);

    // Enable dropped mid-conversion: result still delivered.
    wait_busy("busy_wait_en");
    enable = 1'b0;
    run(500);
    enable = 1'b1;
    run(300);

    // Randomised traffic.
    lat_lo = 1; lat_hi = 4; len_lo = 1; len_hi = 150;
    ready_pct = 60; clr_pct = 3; en_flip = 4;
    run(12000);

    // Reset while the ADC is converting.
    en_flip = 0; clr_pct = 0; clr_flags = 1'b0; enable = 1'b1;
    len_lo = 100; len_hi = 120;
    wait_busy("busy_wait_rst");
    run(5);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    run(1000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
